activity_monitor: RTL and testbench
===================================

Name: activity_monitor

Overview:
Upstream feeder for the power estimator. Observes core control activity (FSM state, PCWrite strobe, recovery-mode flag) and produces the three 32-bit activity counts the estimator weights and sums. Supports free-running or fixed-window sampling, synchronous clear, and counting enable.

Parameters:
STATE_W, 4, width of the observed FSM state encoding
CNT_W, 32, counter and output width; must stay 32 to match the estimator inputs
WINDOW_CYCLES, 0, 0 = free-running live counts; N>0 = snapshot and restart every N enabled cycles

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
fsm_state  input  STATE_W  current FSM state of the monitored core
pc_write  input  1  PCWrite control strobe
recovery_active  input  1  high while the core is in fault-recovery
count_en  input  1  counting enable
clear  input  1  synchronous clear of counters and window
fsm_transition_count  output  CNT_W  FSM state changes counted
pcwrite_toggle_count  output  CNT_W  pc_write edges counted, rising and falling
recovery_cycle_count  output  CNT_W  cycles with recovery_active high
window_done  output  1  one-cycle pulse when a window snapshot is published
overflow  output  1  sticky: a counter hit its maximum

Behaviour:
- One clock domain; reset is asynchronous and active-low (clk, reset_n). Reset asserts immediately and deasserts synchronously by design of the upstream reset synchroniser.
- Reset values: all counts 0, window_done 0, overflow 0, window counter 0, history registers 0, primed 0.
- History registers fsm_state_q and pc_write_q update every cycle, regardless of count_en.
- primed is set on the first clock edge after reset or clear. Transition and toggle events count only when primed=1. This prevents a false event on the first sample.
- Events in cycle t:
  - fsm_ev = primed & (fsm_state != fsm_state_q)
  - pc_ev = primed & (pc_write != pc_write_q)
  - rec_ev = recovery_active
- Each event increments its live counter by 1 when count_en=1. Latency is one cycle: an event in cycle t is visible on the outputs after edge t+1 (free-running mode).
- clear has priority over increments. Same-cycle events are discarded. Live counters, snapshots, window counter, overflow and primed all go to 0 next cycle.
- count_en=0: counters and window counter hold; history still tracks.
- WINDOW_CYCLES=0:
  - Outputs are the live counters.
  - window_done is tied 0.
- WINDOW_CYCLES=N>0:
  - Window counter counts enabled cycles from 0 to N-1.
  - On the enabled cycle where it equals N-1:
    - snapshot <= live + this cycle's increments
    - live <= 0
    - window counter <= 0
    - window_done = 1 for exactly one cycle, aligned with the new snapshot
  - Outputs show the snapshot only; they hold between windows. The first N cycles show 0.
- Counter at all-ones plus increment: behaviour is set by the optional feature.
- overflow is sticky until reset or clear.

Optional Feature:
ACTIVITY_MON_SATURATE_EN
- Defined:
  - Counters saturate at 2^CNT_W-1.
  - overflow sets on the cycle any live counter attempts to increment past its maximum.
- Undefined:
  - Counters wrap modulo 2^CNT_W.
  - overflow sets on the wrap (all-ones to 0) instead.
- Snapshot logic is identical in both builds.

Decomposition:
- Package activity_pkg holds:
  - CNT_W localparam (32)
  - cnt_t typedef
  - function cnt_next(cur, inc) returning the next value and an overflow bit; the macro selects saturate or wrap inside this function.
- Sub-module activity_counter: one live counter with clear, inc and en inputs, plus an ovf output. It is instantiated three times. The top level owns edge detection, primed, the window counter and snapshots.

Test Plan:
1. Reset, then fsm_state sequence 0,0,3,3,5,5,5,2 with count_en=1 and WINDOW_CYCLES=0 -> fsm_transition_count=3 one cycle after the last change. No count from the first post-reset sample, even when fsm_state=7 at reset release.
2. pc_write pattern 0,1,1,0,1,0 -> pcwrite_toggle_count=4. With recovery_active high for 7 cycles -> recovery_cycle_count=7. Drop count_en for 2 of those cycles -> 5.
3. WINDOW_CYCLES=8, recovery_active held high -> window_done pulses at enabled cycles 8, 16, 24. Each snapshot recovery_cycle_count=8. Outputs are 0 before the first pulse.
4. clear asserted in the same cycle as an fsm change and a pc_write edge -> all counts 0 next cycle; the discarded events are not counted. The next change is counted only after primed re-arms.
5. Force a live counter to 32'hFFFF_FFFE, then 3 recovery cycles -> with the macro: 32'hFFFF_FFFF and overflow=1. Without it: 32'h0000_0001 and overflow=1.
6. reset_n asserted mid-window with nonzero counts, asynchronous to clk -> all outputs 0 immediately. Counting resumes cleanly after release.

Source files
------------

// File: rtl/activity_pkg.sv
// activity_pkg: shared counter type and the single-step counter update.
// Build option ACTIVITY_MON_SATURATE_EN: when defined, counters saturate at
// all-ones; otherwise they wrap modulo 2^CNT_W. In both builds the ovf bit
// flags an increment attempted from the all-ones value.
package activity_pkg;

    localparam int CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t value;
        logic ovf;
    } cnt_res_t;

    // Next counter value for one optional increment, plus the overflow flag.
    function automatic cnt_res_t cnt_next(input cnt_t cur, input logic inc);
        cnt_res_t res;
        res.ovf = inc & (&cur);
`ifdef ACTIVITY_MON_SATURATE_EN
        res.value = res.ovf ? cur : cur + cnt_t'(inc);
`else
        res.value = cur + cnt_t'(inc);
`endif
        return res;
    endfunction

endpackage

// File: rtl/activity_counter.sv
// activity_counter: one live event counter with synchronous clear,
// window restart and counting enable. step_value is the value the counter
// would take this cycle (current count plus this cycle's increment), which
// the top level captures as a window snapshot.
module activity_counter
    import activity_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic restart,
    input  logic en,
    input  logic inc,
    output cnt_t count,
    output cnt_t step_value,
    output logic ovf
);

    cnt_t     count_reg;
    cnt_res_t step_next;

    assign step_next  = cnt_next(count_reg, inc);
    assign step_value = step_next.value;
    assign count      = count_reg;
    // An overflow attempt only matters when the increment is actually applied.
    assign ovf        = en & ~clear & step_next.ovf;

    // Count register: clear dominates, restart zeroes at a window boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= restart ? '0 : step_next.value;
        end
    end

endmodule

// File: rtl/activity_monitor.sv
// activity_monitor: counts FSM state changes, pc_write edges and recovery
// cycles for the power estimator. WINDOW_CYCLES=0 exposes the live counts;
// WINDOW_CYCLES=N publishes a snapshot every N enabled cycles.
// Counter overflow behaviour follows ACTIVITY_MON_SATURATE_EN (see activity_pkg).
module activity_monitor #(
    parameter int STATE_W       = 4,
    parameter int CNT_W         = 32,
    parameter int WINDOW_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [STATE_W-1:0] fsm_state,
    input  logic               pc_write,
    input  logic               recovery_active,
    input  logic               count_en,
    input  logic               clear,
    output logic [CNT_W-1:0]   fsm_transition_count,
    output logic [CNT_W-1:0]   pcwrite_toggle_count,
    output logic [CNT_W-1:0]   recovery_cycle_count,
    output logic               window_done,
    output logic               overflow
);
    // CNT_W must equal activity_pkg::CNT_W (32): the estimator inputs are fixed.
    import activity_pkg::*;

    logic [STATE_W-1:0] fsm_state_reg;
    logic               pc_write_reg;
    logic               primed_reg;
    logic               overflow_reg;
    logic [2:0]         inc;
    logic [2:0]         ovf_hit;
    logic               window_end;
    cnt_t               live       [3];
    cnt_t               step_value [3];

    // Channel 0: FSM changes, 1: pc_write edges, 2: recovery cycles.
    // Edge events need a valid previous sample, hence the primed gate.
    assign inc[0] = primed_reg & (fsm_state != fsm_state_reg);
    assign inc[1] = primed_reg & (pc_write != pc_write_reg);
    assign inc[2] = recovery_active;

    // History tracks every cycle, independent of count_en and clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_state_reg <= '0;
            pc_write_reg  <= 1'b0;
        end else begin
            fsm_state_reg <= fsm_state;
            pc_write_reg  <= pc_write;
        end
    end

    // primed arms one edge after reset or clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            primed_reg <= 1'b0;
        end else begin
            primed_reg <= ~clear;
        end
    end

    // Sticky overflow: any live counter overflowing sets it until clear/reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_reg <= 1'b0;
        end else if (clear) begin
            overflow_reg <= 1'b0;
        end else if (|ovf_hit) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            activity_counter u_counter (
                .clk        (clk),
                .reset_n    (reset_n),
                .clear      (clear),
                .restart    (window_end),
                .en         (count_en),
                .inc        (inc[gi]),
                .count      (live[gi]),
                .step_value (step_value[gi]),
                .ovf        (ovf_hit[gi])
            );
        end

        if (WINDOW_CYCLES > 0) begin : g_window
            localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
            localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

            logic [WIN_W-1:0] win_cnt_reg;
            logic             window_done_reg;
            cnt_t             snap_reg [3];

            assign window_end = count_en & ~clear & (win_cnt_reg == WIN_LAST);

            // Window position in enabled cycles, 0 .. WINDOW_CYCLES-1.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    win_cnt_reg <= '0;
                end else if (clear) begin
                    win_cnt_reg <= '0;
                end else if (count_en) begin
                    win_cnt_reg <= window_end ? '0 : win_cnt_reg + WIN_W'(1);
                end
            end

            // Publish live+this-cycle increments at the window end, with a done pulse.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    window_done_reg <= 1'b0;
                    for (int i = 0; i < 3; i++) snap_reg[i] <= '0;
                end else if (clear) begin
                    window_done_reg <= 1'b0;
                    for (int i = 0; i < 3; i++) snap_reg[i] <= '0;
                end else begin
                    window_done_reg <= window_end;
                    if (window_end) begin
                        for (int i = 0; i < 3; i++) snap_reg[i] <= step_value[i];
                    end
                end
            end

            assign fsm_transition_count = snap_reg[0];
            assign pcwrite_toggle_count = snap_reg[1];
            assign recovery_cycle_count = snap_reg[2];
            assign window_done          = window_done_reg;
        end else begin : g_live
            // Step values only feed snapshots; nothing consumes them here.
            logic unused_step;

            assign unused_step          = ^{step_value[0], step_value[1], step_value[2]};
            assign window_end           = 1'b0;
            assign fsm_transition_count = live[0];
            assign pcwrite_toggle_count = live[1];
            assign recovery_cycle_count = live[2];
            assign window_done          = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_activity_monitor.sv
// tb_activity_monitor: directed plus random stimulus on a live-count instance
// and an 8-cycle-window instance, checked against a per-cycle behavioural model.
module tb_activity_monitor;

    localparam int     WIN_B = 8;
    localparam longint MAXV  = 64'h0000_0000_FFFF_FFFF;
`ifdef ACTIVITY_MON_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [3:0]  fsm_state;
    logic        pc_write;
    logic        recovery_active;
    logic        count_en;
    logic        clear;
    logic [31:0] fsm_c [2];
    logic [31:0] tog_c [2];
    logic [31:0] rec_c [2];
    logic        wd    [2];
    logic        ov    [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one set per instance (0: live, 1: windowed).
    bit     m_primed [2];
    int     m_pfsm   [2];
    bit     m_ppc    [2];
    longint m_live   [2][3];
    longint m_snap   [2][3];
    int     m_win    [2];
    bit     m_done   [2];
    bit     m_ovf    [2];

    activity_monitor #(.STATE_W(4), .CNT_W(32), .WINDOW_CYCLES(0)) dut_live (
        .clk                  (clk),
        .reset_n              (reset_n),
        .fsm_state            (fsm_state),
        .pc_write             (pc_write),
        .recovery_active      (recovery_active),
        .count_en             (count_en),
        .clear                (clear),
        .fsm_transition_count (fsm_c[0]),
        .pcwrite_toggle_count (tog_c[0]),
        .recovery_cycle_count (rec_c[0]),
        .window_done          (wd[0]),
        .overflow             (ov[0])
    );

    activity_monitor #(.STATE_W(4), .CNT_W(32), .WINDOW_CYCLES(WIN_B)) dut_win (
        .clk                  (clk),
        .reset_n              (reset_n),
        .fsm_state            (fsm_state),
        .pc_write             (pc_write),
        .recovery_active      (recovery_active),
        .count_en             (count_en),
        .clear                (clear),
        .fsm_transition_count (fsm_c[1]),
        .pcwrite_toggle_count (tog_c[1]),
        .recovery_cycle_count (rec_c[1]),
        .window_done          (wd[1]),
        .overflow             (ov[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int win_len(input int k);
        return (k == 0) ? 0 : WIN_B;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_primed[k] = 1'b0;
            m_pfsm[k]   = 0;
            m_ppc[k]    = 1'b0;
            m_win[k]    = 0;
            m_done[k]   = 1'b0;
            m_ovf[k]    = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_live[k][i] = 0;
                m_snap[k][i] = 0;
            end
        end
    endfunction

    // One rising edge of the model with the inputs that were applied.
    function automatic void model_edge(input int fsm, input bit pc, input bit rec,
                                       input bit en, input bit clr);
        for (int k = 0; k < 2; k++) begin
            bit     ev [3];
            longint nv [3];
            ev[0] = m_primed[k] && (fsm != m_pfsm[k]);
            ev[1] = m_primed[k] && (pc != m_ppc[k]);
            ev[2] = rec;
            if (clr) begin
                m_primed[k] = 1'b0;
                m_win[k]    = 0;
                m_done[k]   = 1'b0;
                m_ovf[k]    = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    m_live[k][i] = 0;
                    m_snap[k][i] = 0;
                end
            end else begin
                m_done[k] = 1'b0;
                if (en) begin
                    for (int i = 0; i < 3; i++) begin
                        nv[i] = m_live[k][i] + (ev[i] ? 64'd1 : 64'd0);
                        if (nv[i] > MAXV) begin
                            m_ovf[k] = 1'b1;
                            nv[i]    = SAT ? MAXV : 64'd0;
                        end
                    end
                    if (win_len(k) > 0 && m_win[k] == win_len(k) - 1) begin
                        for (int i = 0; i < 3; i++) begin
                            m_snap[k][i] = nv[i];
                            m_live[k][i] = 0;
                        end
                        m_win[k]  = 0;
                        m_done[k] = 1'b1;
                    end else begin
                        for (int i = 0; i < 3; i++) m_live[k][i] = nv[i];
                        if (win_len(k) > 0) m_win[k] = m_win[k] + 1;
                    end
                end
                m_primed[k] = 1'b1;
            end
            m_pfsm[k] = fsm;
            m_ppc[k]  = pc;
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            longint e0, e1, e2;
            bit     edone;
            e0    = (win_len(k) == 0) ? m_live[k][0] : m_snap[k][0];
            e1    = (win_len(k) == 0) ? m_live[k][1] : m_snap[k][1];
            e2    = (win_len(k) == 0) ? m_live[k][2] : m_snap[k][2];
            edone = (win_len(k) == 0) ? 1'b0 : m_done[k];
            check($sformatf("u%0d.fsm_transition_count", k), 64'(fsm_c[k]), 64'(e0));
            check($sformatf("u%0d.pcwrite_toggle_count", k), 64'(tog_c[k]), 64'(e1));
            check($sformatf("u%0d.recovery_cycle_count", k), 64'(rec_c[k]), 64'(e2));
            check($sformatf("u%0d.window_done", k), 64'(wd[k]), 64'(edone));
            check($sformatf("u%0d.overflow", k), 64'(ov[k]), 64'(m_ovf[k]));
        end
    endtask

    // Apply inputs (from a falling edge), clock once, advance model, check.
    task automatic cyc(input int fsm, input bit pc, input bit rec, input bit en, input bit clr);
        fsm_state       = 4'(fsm);
        pc_write        = pc;
        recovery_active = rec;
        count_en        = en;
        clear           = clr;
        @(posedge clk);
        model_edge(fsm, pc, rec, en, clr);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int pcpat [6];
        int enpat [7];
        int pulses;

        pcpat = '{0, 1, 1, 0, 1, 0};
        enpat = '{1, 1, 0, 0, 1, 1, 1};

        reset_n         = 1'b1;
        fsm_state       = 4'd7;
        pc_write        = 1'b0;
        recovery_active = 1'b0;
        count_en        = 1'b1;
        clear           = 1'b0;
        model_reset();
        #2 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // Test 1: state 7 at release is not an event; then three changes.
        cyc(7, 0, 0, 1, 0);
        cyc(3, 0, 0, 1, 0);
        cyc(3, 0, 0, 1, 0);
        cyc(5, 0, 0, 1, 0);
        cyc(5, 0, 0, 1, 0);
        cyc(5, 0, 0, 1, 0);
        cyc(2, 0, 0, 1, 0);
        check("t1_fsm_changes", 64'(fsm_c[0]), 64'd3);

        // Test 2: pc_write toggles, recovery cycles, enable gating.
        cyc(2, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) cyc(2, 1'(pcpat[i]), 0, 1, 0);
        check("t2_toggles", 64'(tog_c[0]), 64'd4);
        cyc(2, 0, 0, 1, 1);
        for (int i = 0; i < 7; i++) cyc(2, 0, 1, 1, 0);
        check("t2_recovery", 64'(rec_c[0]), 64'd7);
        cyc(2, 0, 0, 1, 1);
        for (int i = 0; i < 7; i++) cyc(2, 0, 1, 1'(enpat[i]), 0);
        check("t2_recovery_gated", 64'(rec_c[0]), 64'd5);

        // Test 3: windowed snapshots with recovery held high.
        cyc(2, 0, 0, 1, 1);
        pulses = 0;
        for (int i = 0; i < 26; i++) begin
            cyc(2, 0, 1, 1, 0);
            if (wd[1] === 1'b1) pulses++;
        end
        check("t3_pulses", 64'(pulses), 64'd3);
        check("t3_snapshot", 64'(rec_c[1]), 64'd8);

        // Test 4: clear discards same-cycle events; primed re-arms.
        cyc(1, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(4, 1, 0, 1, 1);
        check("t4_clear_fsm", 64'(fsm_c[0]), 64'd0);
        check("t4_clear_tog", 64'(tog_c[0]), 64'd0);
        cyc(4, 1, 0, 1, 0);
        check("t4_arm_fsm", 64'(fsm_c[0]), 64'd0);
        cyc(6, 1, 0, 1, 0);
        check("t4_rearm_fsm", 64'(fsm_c[0]), 64'd1);
        check("t4_rearm_tog", 64'(tog_c[0]), 64'd0);

        // Test 5: recovery counter preloaded near all-ones.
        cyc(6, 1, 0, 1, 1);
        count_en        = 1'b0;
        recovery_active = 1'b0;
        clear           = 1'b0;
        force dut_live.g_cnt[2].u_counter.count_reg = 32'hFFFF_FFFE;
        @(posedge clk);
        model_edge(6, 1, 0, 0, 0);
        #1 release dut_live.g_cnt[2].u_counter.count_reg;
        m_live[0][2] = 64'h0000_0000_FFFF_FFFE;
        @(negedge clk);
        check_all();
        for (int i = 0; i < 3; i++) cyc(6, 1, 1, 1, 0);
        check("t5_recovery", 64'(rec_c[0]), SAT ? 64'h0000_0000_FFFF_FFFF : 64'd1);
        check("t5_overflow", 64'(ov[0]), 64'd1);

        // Test 6: asynchronous reset mid-window.
        cyc(6, 1, 0, 1, 1);
        for (int i = 0; i < 12; i++) cyc(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1, 1, 0);
        check("t6_pre_reset", 64'(rec_c[0]), 64'd12);
        @(posedge clk);
        #3 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cyc(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
